// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch timekeeping core.
//   bcd_t          : one BCD digit (4 bits, legal range 0..9)
//   BCD_ZERO/NINE  : digit limits used by the two-digit counters
//   *_MAX_DEF      : default field limits (minutes 0..99, seconds 0..59)
//   run_state_t    : run/pause state encoding (RUN = 1 so the flop is the flag)
//   bcd2_next()    : next value of a two-digit BCD field with wrap at max
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_NINE = 4'd9;

    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 99;

    typedef enum logic {
        ST_PAUSED = 1'b0,
        ST_RUN    = 1'b1
    } run_state_t;

    // Increment a two-digit BCD value {tens, ones}; the full two-digit value
    // is compared against the limit so that e.g. 59 wraps but 09 or 50 do not.
    function automatic logic [7:0] bcd2_next(
        input bcd_t tens,
        input bcd_t ones,
        input bcd_t max_tens,
        input bcd_t max_ones
    );
        logic [7:0] nxt;
        if ((tens == max_tens) && (ones == max_ones)) begin
            nxt = {BCD_ZERO, BCD_ZERO};
        end else if (ones >= BCD_NINE) begin
            nxt = {tens + 4'd1, BCD_ZERO};
        end else begin
            nxt = {tens, ones + 4'd1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// ---------------------------------------------------------------------------
// bcd2_counter
// Two-digit BCD up-counter that wraps to 00 after MAX.
//   clk, rst_n  : clock, asynchronous active-low reset (clears to 00)
//   inc         : single-cycle increment enable
//   carry_en    : allows the wrap strobe out (used to block carry in adjust)
//   tens, ones  : registered BCD digits
//   wrap        : combinational strobe, inc while the field sits at MAX
// ---------------------------------------------------------------------------
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = SEC_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic carry_en,
    output bcd_t tens,
    output bcd_t ones,
    output logic wrap
);

    localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

    bcd_t tens_r;
    bcd_t ones_r;
    bcd_t tens_nxt_s;
    bcd_t ones_nxt_s;
    logic at_max_s;

    // Detect the field sitting at its limit (full two-digit compare).
    always_comb begin
        at_max_s = 1'b0;
        if ((tens_r == MAX_TENS) && (ones_r == MAX_ONES)) begin
            at_max_s = 1'b1;
        end else begin
            at_max_s = 1'b0;
        end
    end

    // Next digit values and the outgoing wrap strobe.
    always_comb begin
        tens_nxt_s = tens_r;
        ones_nxt_s = ones_r;
        wrap       = 1'b0;
        if (inc) begin
            {tens_nxt_s, ones_nxt_s} = bcd2_next(tens_r, ones_r, MAX_TENS, MAX_ONES);
            wrap = at_max_s & carry_en;
        end else begin
            tens_nxt_s = tens_r;
            ones_nxt_s = ones_r;
            wrap       = 1'b0;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_r <= BCD_ZERO;
            ones_r <= BCD_ZERO;
        end else begin
            tens_r <= tens_nxt_s;
            ones_r <= ones_nxt_s;
        end
    end

    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
// BCD MM:SS timekeeping core feeding the 4-digit seven-segment driver.
//   clk, rst_n         : clock, asynchronous active-low reset
//   tick_1hz, tick_2hz : single-cycle enables from the clock divider
//   pause              : debounced level, toggles run/pause on its rising edge
//   adjust, select     : adjust mode and field select (0 = min, 1 = sec)
//   digit0..digit3     : min tens, min ones, sec tens, sec ones (BCD)
//   running            : 1 while in RUN
//   adjust_o, select_o : registered copies of adjust/select for blinking
// Run mode counts seconds on tick_1hz with carry into minutes (99:59 -> 00:00).
// Adjust mode bumps only the selected field on tick_2hz, no carry.
// ---------------------------------------------------------------------------
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       adjust,
    input  logic       select,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       adjust_o,
    output logic       select_o
);

    run_state_t state_r;
    run_state_t state_nxt_s;
    logic       pause_q_r;
    logic       pause_rise_s;
    logic       adjust_r;
    logic       select_r;
    logic       running_s;

    logic       sec_inc_s;
    logic       sec_carry_en_s;
    logic       sec_wrap_s;
    logic       min_inc_s;
    logic       min_wrap_unused_s;

    bcd_t       sec_tens_s;
    bcd_t       sec_ones_s;
    bcd_t       min_tens_s;
    bcd_t       min_ones_s;

    // Pause edge-detect history and the mode copies for the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q_r <= 1'b0;
            adjust_r  <= 1'b0;
            select_r  <= 1'b0;
        end else begin
            pause_q_r <= pause;
            adjust_r  <= adjust;
            select_r  <= select;
        end
    end

    assign pause_rise_s = pause & ~pause_q_r;

    // Run/pause state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Run/pause next state: every pause rising edge toggles, in any mode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (pause_rise_s) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (pause_rise_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Run/pause outputs: RUN is encoded as 1, so this is a flop bit.
    always_comb begin
        running_s = 1'b0;
        case (state_r)
            ST_RUN:    running_s = 1'b1;
            ST_PAUSED: running_s = 1'b0;
            default:   running_s = 1'b0;
        endcase
    end

    // Field increment steering. Ticks are judged against the current
    // (pre-toggle) run state and the adjust level sampled at this edge.
    always_comb begin
        sec_inc_s      = 1'b0;
        min_inc_s      = 1'b0;
        sec_carry_en_s = 1'b0;
        if (adjust) begin
            sec_inc_s      = tick_2hz & select;
            min_inc_s      = tick_2hz & ~select;
            sec_carry_en_s = 1'b0;
        end else begin
            sec_inc_s      = tick_1hz & running_s;
            min_inc_s      = sec_wrap_s;
            sec_carry_en_s = 1'b1;
        end
    end

    bcd2_counter #(
        .MAX (SEC_MAX)
    ) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sec_inc_s),
        .carry_en (sec_carry_en_s),
        .tens     (sec_tens_s),
        .ones     (sec_ones_s),
        .wrap     (sec_wrap_s)
    );

    // Minutes wrap has no consumer: 99:59 simply rolls to 00:00.
    bcd2_counter #(
        .MAX (MIN_MAX)
    ) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_inc_s),
        .carry_en (1'b1),
        .tens     (min_tens_s),
        .ones     (min_ones_s),
        .wrap     (min_wrap_unused_s)
    );

    assign digit0   = min_tens_s;
    assign digit1   = min_ones_s;
    assign digit2   = sec_tens_s;
    assign digit3   = sec_ones_s;
    assign running  = running_s;
    assign adjust_o = adjust_r;
    assign select_o = select_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
// Directed, table-driven bench for stopwatch_counter plus hand-written
// multi-cycle sequences (long counts, 99:59 rollover, held pause,
// coincident pause/tick, reset between clock edges).
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause;
    logic       adjust;
    logic       select;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       running;
    logic       adjust_o;
    logic       select_o;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        t1;
        logic        t2;
        logic        p;
        logic        a;
        logic        s;
        logic [15:0] d;
        logic        run;
        logic        adj;
        logic        sel;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    stopwatch_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .pause    (pause),
        .adjust   (adjust),
        .select   (select),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .running  (running),
        .adjust_o (adjust_o),
        .select_o (select_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs: drive at negedge, sample 1 after posedge.
    task automatic apply(input logic t1, input logic t2, input logic p,
                         input logic a, input logic s);
        @(negedge clk);
        tick_1hz = t1;
        tick_2hz = t2;
        pause    = p;
        adjust   = a;
        select   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] exp_d,
                         input logic exp_run, input logic exp_adj,
                         input logic exp_sel);
        logic [15:0] got_d;
        got_d = {digit0, digit1, digit2, digit3};
        n_cmp = n_cmp + 1;
        if ((got_d !== exp_d) || (running !== exp_run) ||
            (adjust_o !== exp_adj) || (select_o !== exp_sel)) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got digits=%h run=%b adj=%b sel=%b, want digits=%h run=%b adj=%b sel=%b",
                     name, got_d, running, adjust_o, select_o,
                     exp_d, exp_run, exp_adj, exp_sel);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause    = 1'b0;
        adjust   = 1'b0;
        select   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic repeat_apply(input int n, input logic t1, input logic t2,
                                input logic a, input logic s);
        for (int k = 0; k < n; k++) begin
            apply(t1, t2, 1'b0, a, s);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause    = 1'b0;
        adjust   = 1'b0;
        select   = 1'b0;

        //          t1    t2    p     a     s     digits    run   adj   sel
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0102, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0103, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0103, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0103, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0103, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0104, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0104, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0104, 1'b1, 1'b0, 1'b0};

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].t1, vecs[i].t2, vecs[i].p, vecs[i].a, vecs[i].s);
            check($sformatf("vec%0d", i), vecs[i].d, vecs[i].run,
                  vecs[i].adj, vecs[i].sel);
        end

        // 59 seconds, then the carry into minutes.
        do_reset();
        repeat_apply(59, 1'b1, 1'b0, 1'b0, 1'b0);
        check("count_59", 16'h0059, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("carry_0100", 16'h0100, 1'b1, 1'b0, 1'b0);

        // Preload 99:59 through adjust, then roll over.
        do_reset();
        repeat_apply(99, 1'b0, 1'b1, 1'b1, 1'b0);
        check("adj_min_99", 16'h9900, 1'b1, 1'b1, 1'b0);
        repeat_apply(59, 1'b0, 1'b1, 1'b1, 1'b1);
        check("adj_sec_59", 16'h9959, 1'b1, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rollover_9959", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Pause held high for 10 cycles gives exactly one toggle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("pause_held", 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat_apply(5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("paused_ticks", 16'h0000, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("resume", 16'h0000, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("resume_tick", 16'h0001, 1'b1, 1'b0, 1'b0);

        // Seconds wrap in adjust mode must not carry into minutes.
        do_reset();
        repeat_apply(59, 1'b0, 1'b1, 1'b1, 1'b1);
        check("adj_to_0059", 16'h0059, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("adj_no_carry", 16'h0000, 1'b1, 1'b1, 1'b1);
        repeat_apply(3, 1'b1, 1'b0, 1'b1, 1'b1);
        check("adj_ignores_1hz", 16'h0000, 1'b1, 1'b1, 1'b1);

        // Pause rise coincident with a 1 Hz tick: tick counts, then pause.
        do_reset();
        repeat_apply(10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("count_10", 16'h0010, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_with_tick", 16'h0011, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between clock edges at 12:34.
        do_reset();
        repeat_apply(12, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat_apply(34, 1'b0, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("preload_1234", 16'h1234, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        pause  = 1'b0;
        adjust = 1'b0;
        select = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_reset_tick", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
